// File: rtl/uart_pkg.sv
// Shared UART constants used by the transmitter and its input FIFO.
// Defaults here keep both blocks at the same word width.
package uart_pkg;

  localparam int UART_DBITS            = 16;
  localparam int UART_FIFO_ADDR_BITS   = 4;
  localparam int UART_FIFO_AFULL_LEVEL = 12;

  function automatic int fifo_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/consumer bundle for the UART TX FIFO.
// master = word producer and transmitter side, slave = FIFO.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DBITS     = UART_DBITS,
  parameter int ADDR_BITS = UART_FIFO_ADDR_BITS
);

  logic               wr_en;
  logic [DBITS-1:0]   wr_data;
  logic               rd_en;
  logic [DBITS-1:0]   rd_data;
  logic               empty;
  logic               full;
  logic               almost_full;
  logic [ADDR_BITS:0] count;
  logic               clear_err;
  logic               overflow;
  logic               underflow;

  modport master (
    output wr_en, wr_data, rd_en, clear_err,
    input  rd_data, empty, full, almost_full,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clear_err,
    output rd_data, empty, full, almost_full,
    output count, overflow, underflow
  );

endinterface

// File: rtl/uart_fifo_ctrl.sv
// FIFO pointers, occupancy, status and sticky error flags.
// Error flags exist only when UART_TX_FIFO_ERR_EN is defined.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_BITS   = UART_FIFO_ADDR_BITS,
  parameter int AFULL_LEVEL = UART_FIFO_AFULL_LEVEL
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 rd_en,
`ifdef UART_TX_FIFO_ERR_EN
  input  logic                 clear_err,
`endif
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 wr_accept,
  output logic [ADDR_BITS:0]   count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_BITS:0] DEPTH =
    (ADDR_BITS+1)'(fifo_depth(ADDR_BITS));
  localparam logic [ADDR_BITS:0] AFULL =
    (ADDR_BITS+1)'(AFULL_LEVEL);
  localparam logic [ADDR_BITS:0] ONE_C =
    (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] ONE_P =
    ADDR_BITS'(1);

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 afull_q, afull_d;
  logic                 push, pop;

  always_comb begin
    push     = wr_en & ~full_q;
    pop      = rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE_P;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE_P;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH);
    afull_d = (count_d >= AFULL);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

`ifdef UART_TX_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A fresh rejection beats a simultaneous clear.
  always_comb begin
    ovf_d = (ovf_q & ~clear_err) | (wr_en & full_q);
    unf_d = (unf_q & ~clear_err) | (rd_en & empty_q);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign wr_addr     = wr_ptr_q;
  assign rd_addr     = rd_ptr_q;
  assign wr_accept   = push;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through word buffer in front of uart_transmitter.
// Define UART_TX_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DBITS       = UART_DBITS,
  parameter int ADDR_BITS   = UART_FIFO_ADDR_BITS,
  parameter int AFULL_LEVEL = UART_FIFO_AFULL_LEVEL
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = fifo_depth(ADDR_BITS);

  logic [DBITS-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_addr;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 wr_accept;
  logic                 empty;

  uart_fifo_ctrl #(
    .ADDR_BITS   (ADDR_BITS),
    .AFULL_LEVEL (AFULL_LEVEL)
  ) u_ctrl (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .wr_en       (bus.wr_en),
    .rd_en       (bus.rd_en),
`ifdef UART_TX_FIFO_ERR_EN
    .clear_err   (bus.clear_err),
`endif
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .wr_accept   (wr_accept),
    .count       (bus.count),
    .empty       (empty),
    .full        (bus.full),
    .almost_full (bus.almost_full),
    .overflow    (bus.overflow),
    .underflow   (bus.underflow)
  );

  // Storage is deliberately not reset; empty masks stale words.
  always_ff @(posedge clk_100MHz) begin
    if (wr_accept) mem_q[wr_addr] <= bus.wr_data;
  end

  always_comb begin
    bus.rd_data = empty ? '0 : mem_q[rd_addr];
  end

  assign bus.empty = empty;

endmodule
